// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and constants for the BCD accumulator slice
package bcd_pkg;

   typedef logic [3:0] digit_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam digit_t BCD_MAX  = 4'd9;
   localparam digit_t BCD_CORR = 4'd6;

   function automatic logic bcd_digit_bad(input digit_t d);
      return d > BCD_MAX;
   endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// rtl/bcd_digit_add.sv - combinational single-digit BCD adder with carry in/out
module bcd_digit_add
   import bcd_pkg::*;
(
   input  digit_t i_a,
   input  digit_t i_b,
   input  logic   i_cin,
   output digit_t o_s,
   output logic   o_cout
);

   logic [4:0] w_bin;

   // Non-BCD inputs push the binary sum past 19; the same +6 rule still applies.
   always_comb begin
      w_bin  = {1'b0, i_a} + {1'b0, i_b} + {4'b0000, i_cin};
      o_s    = w_bin[3:0];
      o_cout = 1'b0;
      if (w_bin > {1'b0, BCD_MAX}) begin
         o_s    = w_bin[3:0] + BCD_CORR;
         o_cout = 1'b1;
      end
   end

endmodule

// File: rtl/bcd_accum_seq.sv
// rtl/bcd_accum_seq.sv - digit-serial BCD accumulator sharing one digit adder
// Optional operand digit check with sticky err output: BCD_ACCUM_CHECK_EN
module bcd_accum_seq
   import bcd_pkg::*;
#(
   parameter  int NDIG = 4,
   localparam int DW   = 4 * NDIG
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   input  logic          in_clr,
   output logic [DW-1:0] acc,
   output logic          acc_valid,
   output logic          ovf,
`ifdef BCD_ACCUM_CHECK_EN
   output logic          err,
`endif
   output logic          busy
);

   localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NDIG - 1);

   state_t          r_state;
   state_t          w_next;
   logic [DW-1:0]   r_op;
   logic [DW-1:0]   r_acc;
   logic [IW-1:0]   r_idx;
   logic            r_carry;
   logic            r_ovf;
   logic            w_accept;
   logic            w_last;
   digit_t          w_acc_dig;
   digit_t          w_op_dig;
   digit_t          w_sum;
   logic            w_cout;

   assign w_accept  = in_valid && in_ready;
   assign w_last    = (r_idx == LAST_IDX);
   assign w_acc_dig = r_acc[{r_idx, 2'b00} +: 4];
   assign w_op_dig  = r_op[{r_idx, 2'b00} +: 4];
   assign acc       = r_acc;
   assign ovf       = r_ovf;

   bcd_digit_add u_dig_add (
      .i_a    (w_acc_dig),
      .i_b    (w_op_dig),
      .i_cin  (r_carry),
      .o_s    (w_sum),
      .o_cout (w_cout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      in_ready  = 1'b0;
      busy      = 1'b1;
      acc_valid = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) w_next = ADD;
         end
         ADD: begin
            if (w_last) w_next = DONE;
         end
         DONE: begin
            acc_valid = 1'b1;
            w_next    = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_op    <= '0;
         r_acc   <= '0;
         r_idx   <= '0;
         r_carry <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_op    <= in_data;
                  r_carry <= 1'b0;
                  r_idx   <= '0;
                  if (in_clr) begin
                     r_acc <= '0;
                     r_ovf <= 1'b0;
                  end
               end
            end
            ADD: begin
               r_acc[{r_idx, 2'b00} +: 4] <= w_sum;
               r_carry                    <= w_cout;
               if (w_last) begin
                  r_idx <= '0;
                  if (w_cout) r_ovf <= 1'b1;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef BCD_ACCUM_CHECK_EN
   logic w_bad;
   logic r_err;

   always_comb begin
      w_bad = 1'b0;
      for (int k = 0; k < NDIG; k++) begin
         if (bcd_digit_bad(in_data[4*k +: 4])) w_bad = 1'b1;
      end
   end

   // An in_clr accept restarts the sticky flag from this operand alone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err <= 1'b0;
      end else if (w_accept) begin
         if (in_clr) r_err <= w_bad;
         else        r_err <= r_err | w_bad;
      end
   end

   assign err = r_err;
`endif

endmodule

// File: doc/bcd_accum_seq.md
Name: bcd_accum_seq

Overview:
Sequential controller that accumulates a stream of multi-digit BCD operands using a single shared 4-bit BCD digit adder. Each operand is processed one digit per cycle, least-significant digit first. The carry is held in a register between digits, and the running total is held in a digit-addressed accumulator. The block sits between an upstream operand source (valid/ready handshake) and downstream logic that reads the total.

Parameters:
NDIG, 4, number of BCD digits per operand and per accumulator (1..8)
DW, 4*NDIG, packed operand/accumulator width (derived; not to be overridden)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
in_valid  input  1  operand present on in_data
in_ready  output  1  block can accept an operand this cycle
in_data  input  DW  packed BCD operand; digit k occupies bits [4k+3:4k]
in_clr  input  1  when accepted with in_valid, zero the accumulator before adding
acc  output  DW  current BCD total
acc_valid  output  1  one-cycle pulse when an add completes
ovf  output  1  sticky flag: carry out of the top digit occurred
busy  output  1  FSM not IDLE

Behaviour:
- Reset: acc=0, acc_valid=0, ovf=0, busy=0, in_ready=1, FSM in IDLE, digit index=0, carry reg=0.
- Reset asserted mid-operation aborts the add immediately. The accumulator returns to 0 and the operand is discarded.
- FSM states: IDLE, ADD, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready the block latches in_data into the operand register, clears the carry and the index, and goes to ADD. If in_clr=1, acc is also zeroed and ovf is cleared in the same edge.
- ADD: in_ready=0, busy=1. Each cycle:
  - Feed acc digit[idx], op digit[idx] and the carry reg into the digit adder.
  - Write the sum to acc digit[idx] and the adder's carry out to the carry reg.
  - Increment idx.
  - When idx==NDIG-1 the state moves to DONE. If the final carry out is 1, ovf is set (sticky).
- DONE: acc_valid=1 for exactly one cycle, then return to IDLE. in_ready=0 in DONE.
- Latency: accept edge + NDIG add cycles + 1 DONE cycle. Back-to-back throughput is one operand per NDIG+2 cycles.
- Digit adder rules:
  - Binary sum s = a+b+cin, range 0..19.
  - If s>9, digit = s+6 truncated to 4 bits and carry out = 1.
  - Otherwise digit = s and carry out = 0.
- Invalid input digits (values A-F) are not checked. The result is whatever the correction rule yields, which is deterministic.
- Overflow wraps the total modulo 10^NDIG.
- in_valid while busy is ignored. The source must hold the operand until in_ready.
- in_clr is sampled only on accept.

Optional Feature:
BCD_ACCUM_CHECK_EN
- Defined: the block adds an output err (1 bit, reset 0). On accept, any operand digit >9 sets err sticky. err clears only on an accept with in_clr or on reset. The add still proceeds.
- Undefined: there is no err port and no checking logic.

Decomposition:
- Package bcd_pkg holds:
  - the FSM state enum type (IDLE/ADD/DONE);
  - the constant BCD_MAX=9 and the correction constant 6;
  - a digit typedef (logic [3:0]).
- Sub-module bcd_digit_add: purely combinational one-digit BCD adder (a, b, cin -> s, cout). It is instantiated once and shared across digit cycles.

Test Plan:
- Reset then one accept, NDIG=4, in_clr=1, in_data=16'h1234 -> after 6 cycles acc=16'h1234, acc_valid pulses once, ovf=0.
- Follow-up accept in_data=16'h0879, in_clr=0 -> acc=16'h2113, which exercises the carry ripple across digits 0-2.
- acc=16'h9999 plus in_data=16'h0001 -> acc=16'h0000, ovf=1. A later add of 16'h0001 with in_clr=0 keeps ovf=1.
- in_valid held high continuously with two different operands -> in_ready is low for exactly NDIG+1 cycles between accepts, and the second operand is accepted only after DONE.
- Assert rst during ADD at idx=2 -> all outputs return to their reset values asynchronously, and the next accept of 16'h0005 yields 16'h0005.
- With BCD_ACCUM_CHECK_EN, accept 16'h00A1 -> err=1 and stays 1 until an in_clr accept. Without the macro, the same stimulus produces acc deterministically, with no err port.
